// File: rtl/vga_pkg.sv
// Shared raster constants for the VGA timing path: default 800x600@60
// geometry, derived totals and the counter width used on every axis.
package vga_pkg;

    localparam int CNT_W = 11;
    localparam int MAX_TOTAL = 2 ** CNT_W;

    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FRONT_DEF  = 40;
    localparam int H_SYNC_DEF   = 128;
    localparam int H_BACK_DEF   = 88;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_ACTIVE_DEF = 600;
    localparam int V_FRONT_DEF  = 1;
    localparam int V_SYNC_DEF   = 4;
    localparam int V_BACK_DEF   = 23;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_if.sv
// Raster bundle carried from the timing generator down the draw pipeline.
interface vga_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hblnk;
    logic             vblnk;
    logic             hsync;
    logic             vsync;

    modport out (output hcount, vcount, hblnk, vblnk, hsync, vsync);
    modport in  (input  hcount, vcount, hblnk, vblnk, hsync, vsync);

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus blank/sync flags. Flags are decoded
// from the next count so they land in the same cycle as the count they describe.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   TOTAL       = H_TOTAL_DEF,
    parameter int   BLANK_START = H_ACTIVE_DEF,
    parameter int   SYNC_START  = H_ACTIVE_DEF + H_FRONT_DEF,
    parameter int   SYNC_END    = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF,
    parameter logic POL         = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             blnk,
    output logic             sync,
    output logic             last
);

    localparam cnt_t LAST_C  = cnt_t'(TOTAL - 1);
    localparam cnt_t BLANK_C = cnt_t'(BLANK_START);
    localparam cnt_t SSTART  = cnt_t'(SYNC_START);
    localparam cnt_t SEND    = cnt_t'(SYNC_END);

    cnt_t count_nxt;

    assign last = (count == LAST_C);

    // Next count: advance when enabled, wrap after the final position.
    always_comb begin
        count_nxt = count;
        if (en) begin
            count_nxt = last ? '0 : count + cnt_t'(1);
        end
    end

    // Register the count together with its decoded flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            blnk  <= 1'b0;
            sync  <= ~POL;
        end else begin
            count <= count_nxt;
            blnk  <= (count_nxt >= BLANK_C);
            sync  <= ((count_nxt >= SSTART) && (count_nxt < SEND)) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: horizontal/vertical counters with blank and sync,
// plus a once-per-frame tick at the start of vertical blanking and a
// free-running frame counter for game pacing.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FRONT  = H_FRONT_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BACK   = H_BACK_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FRONT  = V_FRONT_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BACK   = V_BACK_DEF,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.out          vga_out,
    output logic        frame_tick,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam cnt_t V_ACTIVE_C = cnt_t'(V_ACTIVE);

    // Both axes must fit the 11-bit counters.
    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, MAX_TOTAL);
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, MAX_TOTAL);
    end

    cnt_t h_count;
    cnt_t v_count;
    cnt_t h_nxt;
    cnt_t v_nxt;
    logic h_blnk;
    logic h_sync;
    logic h_last;
    logic v_blnk;
    logic v_sync;
    logic v_last;

    vga_axis_counter #(
        .TOTAL       (H_TOTAL),
        .BLANK_START (H_ACTIVE),
        .SYNC_START  (H_ACTIVE + H_FRONT),
        .SYNC_END    (H_ACTIVE + H_FRONT + H_SYNC),
        .POL         (SYNC_POL)
    ) u_h (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .count (h_count),
        .blnk  (h_blnk),
        .sync  (h_sync),
        .last  (h_last)
    );

    vga_axis_counter #(
        .TOTAL       (V_TOTAL),
        .BLANK_START (V_ACTIVE),
        .SYNC_START  (V_ACTIVE + V_FRONT),
        .SYNC_END    (V_ACTIVE + V_FRONT + V_SYNC),
        .POL         (SYNC_POL)
    ) u_v (
        .clk   (clk),
        .rst   (rst),
        .en    (h_last),
        .count (v_count),
        .blnk  (v_blnk),
        .sync  (v_sync),
        .last  (v_last)
    );

    // Next-state counts, so the tick registers alongside the counters.
    assign h_nxt = h_last ? '0 : h_count + cnt_t'(1);
    assign v_nxt = h_last ? (v_last ? '0 : v_count + cnt_t'(1)) : v_count;

    assign vga_out.hcount = h_count;
    assign vga_out.vcount = v_count;
    assign vga_out.hblnk  = h_blnk;
    assign vga_out.vblnk  = v_blnk;
    assign vga_out.hsync  = h_sync;
    assign vga_out.vsync  = v_sync;

    // Tick on entry to vertical blanking; the counter absorbs it one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            frame_tick <= (h_nxt == '0) && (v_nxt == V_ACTIVE_C);
            frame_cnt  <= frame_cnt + {15'd0, frame_tick};
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-geometry instances (one per sync
// polarity) checked every cycle against a model that derives the raster
// purely from elapsed cycles since reset.
module tb_vga_timing_gen;

    typedef struct {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit pol;
    } geom_t;

    typedef struct {
        int h; int v;
        bit hb; bit vb; bit hs; bit vs; bit tick;
    } exp_t;

    localparam geom_t G_FULL = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1};
    localparam geom_t G_P    = '{16, 4, 6, 6, 10, 1, 2, 3, 1'b1};
    localparam geom_t G_N    = '{20, 2, 3, 5, 8, 2, 3, 1, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_p, tick_n;
    logic [15:0] cnt_p, cnt_n;
    int          vectors = 0;
    int          miscompares = 0;
    int          fail_prints = 0;
    int          force_req = 0;
    bit          done = 1'b0;

    vga_if vif_p ();
    vga_if vif_n ();

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_ACTIVE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
        .SYNC_POL(1'b1)
    ) dut_p (
        .clk(clk), .rst(rst), .vga_out(vif_p),
        .frame_tick(tick_p), .frame_cnt(cnt_p)
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
        .V_ACTIVE(8), .V_FRONT(2), .V_SYNC(3), .V_BACK(1),
        .SYNC_POL(1'b0)
    ) dut_n (
        .clk(clk), .rst(rst), .vga_out(vif_n),
        .frame_tick(tick_n), .frame_cnt(cnt_n)
    );

    // Raster position and flags t cycles after reset release.
    function automatic exp_t expect_at(input int t, input geom_t g);
        exp_t e;
        int ht, vt, f;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;
        f = t % (ht * vt);
        e.h = f % ht;
        e.v = f / ht;
        e.hb = (e.h >= g.ha);
        e.vb = (e.v >= g.va);
        e.hs = ((e.h >= g.ha + g.hf) && (e.h < g.ha + g.hf + g.hs)) ? g.pol : !g.pol;
        e.vs = ((e.v >= g.va + g.vf) && (e.v < g.va + g.vf + g.vs)) ? g.pol : !g.pol;
        e.tick = (e.h == 0) && (e.v == g.va);
        return e;
    endfunction

    task automatic pin(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL pin_%s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic check_one(input string nm, input int t, input exp_t e,
                             input logic [15:0] ecnt,
                             input logic [10:0] hc, input logic [10:0] vc,
                             input logic hb, input logic vb, input logic hs,
                             input logic vs, input logic tk, input logic [15:0] fc);
        vectors++;
        if (hc !== 11'(e.h) || vc !== 11'(e.v) || hb !== e.hb || vb !== e.vb ||
            hs !== e.hs || vs !== e.vs || tk !== e.tick || fc !== ecnt) begin
            miscompares++;
            if (fail_prints < 20) begin
                fail_prints++;
                $display("FAIL %s t=%0d: got h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b tick=%b cnt=%0d, want h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b tick=%b cnt=%0d",
                         nm, t, hc, vc, hb, vb, hs, vs, tk, fc,
                         e.h, e.v, e.hb, e.vb, e.hs, e.vs, e.tick, ecnt);
            end
        end
    endtask

    // Model pins on the full 800x600 geometry, then per-cycle comparison.
    initial begin : compare
        int tp, tn, fseen;
        logic [15:0] mcp, mcn;
        exp_t e;
        tp = 0; tn = 0; fseen = 0; mcp = 16'd0; mcn = 16'd0;

        e = expect_at(799, G_FULL);    pin("hb_799", int'(e.hb), 0);
        e = expect_at(800, G_FULL);    pin("hb_800", int'(e.hb), 1);
        e = expect_at(839, G_FULL);    pin("hs_839", int'(e.hs), 0);
        e = expect_at(840, G_FULL);    pin("hs_840", int'(e.hs), 1);
        e = expect_at(967, G_FULL);    pin("hs_967", int'(e.hs), 1);
        e = expect_at(968, G_FULL);    pin("hs_968", int'(e.hs), 0);
        e = expect_at(1056, G_FULL);   pin("v_line1", e.v, 1);
        e = expect_at(633600, G_FULL); pin("tick_first", int'(e.tick), 1);
        e = expect_at(633600, G_FULL); pin("vb_600", int'(e.vb), 1);
        e = expect_at(633600, G_FULL); pin("vs_600", int'(e.vs), 0);
        e = expect_at(634656, G_FULL); pin("vs_601", int'(e.vs), 1);
        e = expect_at(638880, G_FULL); pin("vs_605", int'(e.vs), 0);
        e = expect_at(663167, G_FULL); pin("v_last", e.v, 627);
        e = expect_at(663168, G_FULL); pin("v_wrap", e.v, 0);

        while (!done) begin
            @(posedge clk);
            if (force_req != fseen) begin
                mcp = 16'hFFFF;
                fseen = force_req;
            end
            if (rst) begin
                tp = 0; tn = 0; mcp = 16'd0; mcn = 16'd0;
            end else begin
                e = expect_at(tp, G_P);
                if (e.tick) mcp = mcp + 16'd1;
                tp++;
                e = expect_at(tn, G_N);
                if (e.tick) mcn = mcn + 16'd1;
                tn++;
            end
            #1;
            check_one("pos", tp, expect_at(tp, G_P), mcp,
                      vif_p.hcount, vif_p.vcount, vif_p.hblnk, vif_p.vblnk,
                      vif_p.hsync, vif_p.vsync, tick_p, cnt_p);
            check_one("neg", tn, expect_at(tn, G_N), mcn,
                      vif_n.hcount, vif_n.vcount, vif_n.hblnk, vif_n.vblnk,
                      vif_n.hsync, vif_n.vsync, tick_n, cnt_n);
        end
    end

    // Stimulus: reset release, several frames, short resets, counter wrap, random bursts.
    initial begin : stim
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3 * 512 + 50) @(negedge clk);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        repeat (400) @(negedge clk);
        force dut_p.frame_cnt = 16'hFFFF;
        force_req++;
        @(negedge clk);
        release dut_p.frame_cnt;
        repeat (1200) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(50, 1500)) @(negedge clk);
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst = 1'b0;
        end
        repeat (1100) @(negedge clk);

        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
